// File: rtl/vlc_bit_packer_if.sv
// Stream bundle between the VLC lookup, the bit packer and the downstream word consumer.
// The slave side is the packer; the master side drives codes and sinks packed words.
interface vlc_bit_packer_if #(
    parameter int unsigned CODE_W = 16,
    parameter int unsigned OUT_W  = 32
);
    logic [CODE_W+5:0] vlc_code;
    logic              vlc_valid;
    logic              vlc_ready;
    logic              flush;
    logic [OUT_W-1:0]  pack_data;
    logic              pack_valid;
    logic              pack_ready;
    logic              pack_last;
    logic [2:0]        pack_bytes;

    modport master (
        output vlc_code, vlc_valid, flush, pack_ready,
        input  vlc_ready, pack_data, pack_valid, pack_last, pack_bytes
    );

    modport slave (
        input  vlc_code, vlc_valid, flush, pack_ready,
        output vlc_ready, pack_data, pack_valid, pack_last, pack_bytes
    );
endinterface

// File: rtl/vlc_bit_packer.sv
// Packs variable-length codes MSB-first into 32-bit words; a flush emits a zero-padded
// tail word flagged with pack_last and its valid byte count.
module vlc_bit_packer #(
    parameter int unsigned CODE_W = 16,
    parameter int unsigned OUT_W  = 32
) (
    input logic             clk,
    input logic             rst,
    vlc_bit_packer_if.slave bus
);
    localparam int unsigned AccW = OUT_W + CODE_W;
    localparam int unsigned CntW = $clog2(AccW);
    localparam int unsigned LenW = $clog2(CODE_W) + 1;
    localparam logic [CntW-1:0] AccWC = CntW'(AccW);
    localparam logic [CntW-1:0] OutWC = CntW'(OUT_W);

    typedef enum logic [1:0] {StRun, StDrain, StTail} state_e;

    state_e            state_q, state_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [OUT_W-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [2:0]        bytes_q, bytes_d;

    logic              out_free;
    logic              have_word;
    logic              ready_int;
    logic              xfer;
    logic              emit_full;
    logic [LenW-1:0]   len_raw;
    logic [LenW-1:0]   len;
    logic [CODE_W-1:0] code_m;
    logic [CntW-1:0]   ins_sh;
    logic [CntW-1:0]   cnt_p7;
    logic              unused_spare;

    assign unused_spare = bus.vlc_code[CODE_W+LenW];

    always_comb begin
        out_free  = !valid_q || bus.pack_ready;
        have_word = cnt_q >= OutWC;
        ready_int = (state_q == StRun) && !have_word && !pend_q;
        xfer      = bus.vlc_valid && ready_int;
        len_raw   = bus.vlc_code[CODE_W +: LenW];
        len       = (len_raw > LenW'(CODE_W)) ? LenW'(CODE_W) : len_raw;
        // Keep only the low len bits of the code.
        code_m    = bus.vlc_code[CODE_W-1:0] & ~({CODE_W{1'b1}} << len);
        // Places the code so its MSB lands at acc[AccW-1-cnt].
        ins_sh    = AccWC - cnt_q - CntW'(len);
        cnt_p7    = cnt_q + CntW'(7);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            acc_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            bytes_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            bytes_q <= bytes_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        bytes_d   = bytes_q;
        emit_full = 1'b0;
        if (out_free) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StRun: begin
                if (xfer) begin
                    acc_d = acc_q | (AccW'(code_m) << ins_sh);
                    cnt_d = cnt_q + CntW'(len);
                end else if (out_free && have_word) begin
                    emit_full = 1'b1;
                end
                // A flush during a stall is remembered and taken once the register frees.
                if (bus.flush || pend_q) begin
                    if (out_free) begin
                        state_d = StDrain;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (out_free) begin
                    if (have_word) begin
                        emit_full = 1'b1;
                    end else begin
                        state_d = StTail;
                    end
                end
            end
            StTail: begin
                if (out_free) begin
                    data_d  = acc_q[AccW-1 -: OUT_W];
                    valid_d = 1'b1;
                    last_d  = 1'b1;
                    bytes_d = 3'(cnt_p7 >> 3);
                    acc_d   = '0;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase

        if (emit_full) begin
            data_d  = acc_q[AccW-1 -: OUT_W];
            valid_d = 1'b1;
            last_d  = 1'b0;
            bytes_d = 3'd4;
            acc_d   = acc_q << OUT_W;
            cnt_d   = cnt_q - OutWC;
        end
    end

    always_comb begin
        bus.vlc_ready  = ready_int;
        bus.pack_data  = data_q;
        bus.pack_valid = valid_q;
        bus.pack_last  = last_q;
        bus.pack_bytes = bytes_q;
    end
endmodule

// File: tb/tb_vlc_bit_packer.sv
// Directed bench for vlc_bit_packer: a bit-queue model feeds a scoreboard of expected words
// that a negedge monitor compares against every accepted output word.
module tb_vlc_bit_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    vlc_bit_packer_if #(.CODE_W(16), .OUT_W(32)) bus ();

    vlc_bit_packer #(.CODE_W(16), .OUT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic [2:0]  b;
    } exp_t;

    exp_t exp_q[$];
    bit   mbits[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_word();
        exp_t e;
        e = '0;
        for (int i = 0; i < 32; i++) e.d[31-i] = mbits[i];
        e.l = 1'b0;
        e.b = 3'd4;
        exp_q.push_back(e);
        mbits.delete();
    endtask

    task automatic model_flush();
        exp_t e;
        int   n;
        e = '0;
        n = mbits.size();
        for (int i = 0; i < n; i++) e.d[31-i] = mbits[i];
        e.l = 1'b1;
        e.b = 3'((n + 7) / 8);
        exp_q.push_back(e);
        mbits.delete();
    endtask

    task automatic model_push(input logic [4:0] len, input logic [15:0] code);
        int le;
        le = (len > 5'd16) ? 16 : int'(len);
        for (int i = le - 1; i >= 0; i--) begin
            mbits.push_back(code[i]);
            if (mbits.size() == 32) model_word();
        end
    endtask

    task automatic send(input logic [4:0] len, input logic [15:0] code, input bit with_flush);
        int n;
        n = 0;
        bus.vlc_code  = {code[0], len, code};
        bus.vlc_valid = 1'b1;
        @(negedge clk);
        while (!bus.vlc_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.vlc_ready) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout: vlc_ready got 0 expected 1");
        end
        bus.flush = with_flush;
        tick();
        bus.vlc_valid = 1'b0;
        bus.flush     = 1'b0;
        model_push(len, code);
        if (with_flush) model_flush();
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        model_flush();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || bus.pack_valid) && n < 300);
        if (exp_q.size() != 0 || bus.pack_valid) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout: %0d words still expected", exp_q.size());
        end
        tick();
    endtask

    // Scoreboard monitor plus stability check of a stalled output word.
    logic stall_prev = 1'b0;
    exp_t held;
    exp_t want;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_stable", {bus.pack_valid, bus.pack_data, bus.pack_last, bus.pack_bytes},
                      {1'b1, held});
            end
            if (bus.pack_valid && bus.pack_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_word: got %08h expected none", bus.pack_data);
                end else begin
                    want = exp_q.pop_front();
                    check("word", {bus.pack_data, bus.pack_last, bus.pack_bytes}, want);
                end
            end
            stall_prev = bus.pack_valid && !bus.pack_ready;
            held       = {bus.pack_data, bus.pack_last, bus.pack_bytes};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.vlc_code   = '0;
        bus.vlc_valid  = 1'b0;
        bus.flush      = 1'b0;
        bus.pack_ready = 1'b1;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_data", bus.pack_data, 32'h0);
        check("rst_valid", bus.pack_valid, 1'b0);
        check("rst_last", bus.pack_last, 1'b0);
        check("rst_bytes", bus.pack_bytes, 3'd0);
        check("rst_ready", bus.vlc_ready, 1'b1);
        tick();

        // Two 16-bit codes form one word one cycle after the second accept.
        send(5'd16, 16'hABCD, 1'b0);
        send(5'd16, 16'h1234, 1'b0);
        @(negedge clk);
        check("lat_early", bus.pack_valid, 1'b0);
        @(negedge clk);
        check("lat_valid", bus.pack_valid, 1'b1);
        check("lat_cnt_zero", bus.vlc_ready, 1'b1);
        wait_idle();

        // Eight nibbles, then a ninth and a separate flush.
        for (int i = 1; i <= 8; i++) send(5'd4, 16'(i), 1'b0);
        send(5'd4, 16'h0009, 1'b0);
        do_flush();
        wait_idle();

        // Masking, zero length and length clamping.
        send(5'd4, 16'hFFFF, 1'b0);
        @(negedge clk);
        check("len0_ready", bus.vlc_ready, 1'b1);
        tick();
        send(5'd0, 16'hFFFF, 1'b0);
        send(5'd28, 16'h0000, 1'b0);
        do_flush();
        wait_idle();

        // Backpressure: one word stalled while 32 more bits arrive.
        bus.pack_ready = 1'b0;
        send(5'd16, 16'h1357, 1'b0);
        send(5'd16, 16'h9BDF, 1'b0);
        send(5'd16, 16'h2468, 1'b0);
        send(5'd16, 16'hACE0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("bp_ready_low", bus.vlc_ready, 1'b0);
            check("bp_valid", bus.pack_valid, 1'b1);
            check("bp_data", bus.pack_data, exp_q[0].d);
        end
        tick();
        bus.pack_ready = 1'b1;
        wait_idle();

        // Flush on an empty accumulator, then flush coincident with a transfer.
        do_flush();
        wait_idle();
        send(5'd3, 16'h0005, 1'b1);
        wait_idle();

        // Flush during a stall is held pending and blocks input.
        bus.pack_ready = 1'b0;
        send(5'd16, 16'hDEAD, 1'b0);
        send(5'd16, 16'hF00D, 1'b0);
        send(5'd8, 16'h005A, 1'b0);
        do_flush();
        repeat (2) begin
            @(negedge clk);
            check("pend_block", bus.vlc_ready, 1'b0);
        end
        tick();
        bus.pack_ready = 1'b1;
        wait_idle();

        // Reset mid-stream with cnt=23 and a word stalled.
        bus.pack_ready = 1'b0;
        send(5'd16, 16'h1111, 1'b0);
        send(5'd16, 16'h2222, 1'b0);
        send(5'd16, 16'h3333, 1'b0);
        send(5'd7, 16'h007F, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        mbits.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mrst_data", bus.pack_data, 32'h0);
        check("mrst_valid", bus.pack_valid, 1'b0);
        check("mrst_last", bus.pack_last, 1'b0);
        check("mrst_bytes", bus.pack_bytes, 3'd0);
        check("mrst_ready", bus.vlc_ready, 1'b1);
        tick();
        bus.pack_ready = 1'b1;
        send(5'd16, 16'hCAFE, 1'b0);
        send(5'd16, 16'hBEEF, 1'b0);
        wait_idle();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
